// File: rtl/bcd_ssd_pkg.sv
// Shared constants, segment patterns and decode helper for the BCD up/down counter with scan driver.
package bcd_ssd_pkg;

   localparam int SEG_W = 8;
   localparam int BCD_W = 4;

   localparam int DEF_DIGITS   = 4;
   localparam int DEF_TICK_DIV = 100_000_000;
   localparam int DEF_SCAN_DIV = 100_000;

   typedef logic [BCD_W-1:0] bcd_t;
   typedef logic [SEG_W-1:0] seg_t;

   // Active-low {a,b,c,d,e,f,g,dp}; dp is always off
   localparam seg_t SEG_0     = 8'h03;
   localparam seg_t SEG_1     = 8'h9F;
   localparam seg_t SEG_2     = 8'h25;
   localparam seg_t SEG_3     = 8'h0D;
   localparam seg_t SEG_4     = 8'h99;
   localparam seg_t SEG_5     = 8'h49;
   localparam seg_t SEG_6     = 8'h41;
   localparam seg_t SEG_7     = 8'h1F;
   localparam seg_t SEG_8     = 8'h01;
   localparam seg_t SEG_9     = 8'h09;
   localparam seg_t SEG_BLANK = 8'hFF;

   function automatic seg_t seg_decode(input bcd_t d);
      case (d)
         4'd0:    return SEG_0;
         4'd1:    return SEG_1;
         4'd2:    return SEG_2;
         4'd3:    return SEG_3;
         4'd4:    return SEG_4;
         4'd5:    return SEG_5;
         4'd6:    return SEG_6;
         4'd7:    return SEG_7;
         4'd8:    return SEG_8;
         4'd9:    return SEG_9;
         default: return SEG_BLANK;
      endcase
   endfunction

endpackage

// File: rtl/bcd_updown_ssd_digit.sv
// One BCD digit of the up/down counter; carry/borrow flag that the next inc/dec would roll over.
module bcd_digit
   import bcd_ssd_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic inc,
   input  logic dec,
   input  logic clr,
   output bcd_t value,
   output logic carry,
   output logic borrow
);

   bcd_t r_val;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_val <= '0;
      else if (clr)
         r_val <= '0;
      else if (inc)
         r_val <= (r_val == 4'd9) ? 4'd0 : r_val + 4'd1;
      else if (dec)
         r_val <= (r_val == 4'd0) ? 4'd9 : r_val - 4'd1;
   end

   assign value  = r_val;
   assign carry  = (r_val == 4'd9);
   assign borrow = (r_val == 4'd0);

endmodule

// File: rtl/bcd_updown_ssd.sv
// N-digit BCD up/down counter with tick prescaler and multiplexed 7-segment scan driver.
// Optional build macro BCD_SSD_BLANK_LEADING_ZERO_EN blanks leading-zero digits above digit 0.
module bcd_updown_ssd
   import bcd_ssd_pkg::*;
#(
   parameter int DIGITS   = DEF_DIGITS,
   parameter int TICK_DIV = DEF_TICK_DIV,
   parameter int SCAN_DIV = DEF_SCAN_DIV
)(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    en,
   input  logic                    up,
   input  logic                    clr,
   output logic [BCD_W*DIGITS-1:0] count,
   output logic                    wrap,
   output logic [SEG_W-1:0]        segs,
   output logic [DIGITS-1:0]       ssd_ctl
);

   localparam int TW = $clog2(TICK_DIV);
   localparam int SW = $clog2(SCAN_DIV);
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
   localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
   localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

   logic [TW-1:0]     r_tick_cnt;
   logic              w_tick;
   logic [DIGITS-1:0] w_inc, w_dec, w_carry, w_borrow;
   bcd_t              w_dig [DIGITS];
   logic              r_wrap;
   logic [SW-1:0]     r_scan_cnt;
   logic [IW-1:0]     r_idx;
   logic [DIGITS-1:0] w_blank;
   seg_t              r_segs;
   logic [DIGITS-1:0] r_ssd_ctl;

   // clr wins over en and suppresses the tick in the same cycle
   assign w_tick = en & ~clr & (r_tick_cnt == TICK_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_tick_cnt <= '0;
      else if (clr)
         r_tick_cnt <= '0;
      else if (en)
         r_tick_cnt <= (r_tick_cnt == TICK_LAST) ? '0 : r_tick_cnt + TW'(1);
   end

   for (genvar k = 0; k < DIGITS; k++) begin : g_digit
      if (k == 0) begin : g_lsd
         assign w_inc[k] = w_tick & up;
         assign w_dec[k] = w_tick & ~up;
      end else begin : g_upper
         assign w_inc[k] = w_inc[k-1] & w_carry[k-1];
         assign w_dec[k] = w_dec[k-1] & w_borrow[k-1];
      end

      bcd_digit u_digit (
         .clk    (clk),
         .rst_n  (rst_n),
         .inc    (w_inc[k]),
         .dec    (w_dec[k]),
         .clr    (clr),
         .value  (w_dig[k]),
         .carry  (w_carry[k]),
         .borrow (w_borrow[k])
      );

      assign count[k*BCD_W +: BCD_W] = w_dig[k];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_wrap <= 1'b0;
      else
         r_wrap <= (w_inc[DIGITS-1] & w_carry[DIGITS-1]) |
                   (w_dec[DIGITS-1] & w_borrow[DIGITS-1]);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_scan_cnt <= '0;
         r_idx      <= '0;
      end else if (r_scan_cnt == SCAN_LAST) begin
         r_scan_cnt <= '0;
         r_idx      <= (r_idx == IDX_LAST) ? '0 : r_idx + IW'(1);
      end else begin
         r_scan_cnt <= r_scan_cnt + SW'(1);
      end
   end

`ifdef BCD_SSD_BLANK_LEADING_ZERO_EN
   // A digit blanks only when it and every digit above it are zero
   always_comb begin
      logic w_run;
      w_run   = 1'b1;
      w_blank = '0;
      for (int i = DIGITS - 1; i > 0; i--) begin
         w_run      = w_run & (w_dig[i] == 4'd0);
         w_blank[i] = w_run;
      end
   end
`else
   assign w_blank = '0;
`endif

   // Select and segments come from the same index sample, so they always match
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ssd_ctl <= ~(DIGITS'(1));
         r_segs    <= SEG_0;
      end else begin
         r_ssd_ctl <= ~(DIGITS'(1) << r_idx);
         r_segs    <= w_blank[r_idx] ? SEG_BLANK : seg_decode(w_dig[r_idx]);
      end
   end

   assign wrap    = r_wrap;
   assign segs    = r_segs;
   assign ssd_ctl = r_ssd_ctl;

endmodule

// File: tb/tb_bcd_updown_ssd.sv
// Scoreboard bench for bcd_updown_ssd: a 2-digit instance for counting, a 4-digit one for scan/decode.
`timescale 1ns/1ps
module tb_bcd_updown_ssd;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        a_en, a_up, a_clr, b_en, b_up, b_clr;
   logic [7:0]  a_count;
   logic        a_wrap;
   logic [7:0]  a_segs;
   logic [1:0]  a_ssd;
   logic [15:0] b_count;
   logic        b_wrap;
   logic [7:0]  b_segs;
   logic [3:0]  b_ssd;

   bcd_updown_ssd #(.DIGITS(2), .TICK_DIV(4), .SCAN_DIV(2)) dut_a (
      .clk(clk), .rst_n(rst_n), .en(a_en), .up(a_up), .clr(a_clr),
      .count(a_count), .wrap(a_wrap), .segs(a_segs), .ssd_ctl(a_ssd)
   );

   bcd_updown_ssd #(.DIGITS(4), .TICK_DIV(2), .SCAN_DIV(3)) dut_b (
      .clk(clk), .rst_n(rst_n), .en(b_en), .up(b_up), .clr(b_clr),
      .count(b_count), .wrap(b_wrap), .segs(b_segs), .ssd_ctl(b_ssd)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct { logic [7:0] cnt; logic wr; int gap; } a_exp_t;
   typedef struct { logic [3:0] sel; logic [7:0] seg; } b_exp_t;
   a_exp_t qa[$];
   b_exp_t qb[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] to_bcd2(input int n);
      return {4'(n / 10), 4'(n % 10)};
   endfunction

   task automatic pa(input logic [7:0] c, input logic w, input int g);
      a_exp_t e;
      e.cnt = c; e.wr = w; e.gap = g;
      qa.push_back(e);
   endtask

   task automatic pb(input logic [3:0] s, input logic [7:0] g);
      b_exp_t e;
      e.sel = s; e.seg = g;
      qb.push_back(e);
   endtask

   task automatic cyc_n(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_sel(input logic [3:0] sel, input logic [7:0] exp_segs, input string name);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (b_ssd !== sel && n < 20);
      if (b_ssd !== sel) begin
         total++;
         bad++;
         $display("FAIL %s_timeout: ssd_ctl=%b expected %b", name, b_ssd, sel);
      end else begin
         chk(name, b_segs, exp_segs);
      end
   endtask

   // Counter monitor: every change of count (or a wrap pulse) consumes one expectation
   logic [7:0] a_prev = 8'h00;
   int         a_last = 0;
   always @(negedge clk) begin
      if (a_count !== a_prev || a_wrap === 1'b1) begin
         if (qa.size() == 0) begin
            total++;
            bad++;
            $display("FAIL a_unexpected: count=%h wrap=%b with nothing expected", a_count, a_wrap);
         end else begin
            a_exp_t e;
            e = qa.pop_front();
            chk("a_count", a_count, e.cnt);
            chk("a_wrap", a_wrap, e.wr);
            if (e.gap != 0) chk("a_tick_gap", cyc - a_last, e.gap);
         end
         a_last = cyc;
         a_prev = a_count;
      end
   end

   // Scan monitor: while armed, every select/segment change consumes one expectation
   logic        b_mon = 1'b0;
   logic [11:0] b_prev = '0;
   int          b_last = 0;
   always @(negedge clk) begin
      if (!b_mon) begin
         b_prev = {b_ssd, b_segs};
         b_last = cyc;
      end else if ({b_ssd, b_segs} !== b_prev) begin
         if (qb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL b_unexpected: ssd_ctl=%b segs=%h with nothing expected", b_ssd, b_segs);
         end else begin
            b_exp_t e;
            e = qb.pop_front();
            chk("b_ssd_ctl", b_ssd, e.sel);
            chk("b_segs", b_segs, e.seg);
            chk("b_scan_gap", cyc - b_last, 3);
         end
         b_prev = {b_ssd, b_segs};
         b_last = cyc;
      end
   end

   initial begin
      rst_n = 1'b0;
      a_en = 1'b0; a_up = 1'b0; a_clr = 1'b0;
      b_en = 1'b0; b_up = 1'b1; b_clr = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_a_count", a_count, 8'h00);
      chk("rst_a_wrap", a_wrap, 1'b0);
      chk("rst_a_ssd", a_ssd, 2'b10);
      chk("rst_a_segs", a_segs, 8'h03);
      chk("rst_b_count", b_count, 16'h0000);
      chk("rst_b_ssd", b_ssd, 4'b1110);
      chk("rst_b_segs", b_segs, 8'h03);

      // Up count through 99 -> 00 wrap, one step every 4 cycles
      rst_n = 1'b1; a_en = 1'b1; a_up = 1'b1;
      for (int n = 1; n <= 99; n++) pa(to_bcd2(n), 1'b0, (n == 1) ? 0 : 4);
      pa(8'h00, 1'b1, 4);
      cyc_n(400);

      // Climb to 37, freeze mid-period, resume: the gap stretches by the frozen cycles
      for (int n = 1; n <= 37; n++) pa(to_bcd2(n), 1'b0, 4);
      cyc_n(150);
      a_en = 1'b0;
      cyc_n(10);
      chk("hold_count", a_count, 8'h37);
      pa(8'h38, 1'b0, 14);
      a_en = 1'b1;
      cyc_n(5);

      // Clear lands on the tick edge: count goes to 00 with no wrap
      a_clr = 1'b1;
      pa(8'h00, 1'b0, 4);
      cyc_n(1);
      a_clr = 1'b0; a_up = 1'b0;

      // Down from 00: wrap to 99, then all the way to 00 and wrap again
      pa(8'h99, 1'b1, 4);
      for (int n = 98; n >= 0; n--) pa(to_bcd2(n), 1'b0, 4);
      pa(8'h99, 1'b1, 4);
      cyc_n(404);

      // Direction toggles between ticks; only the value at the tick counts
      a_up = 1'b1;
      cyc_n(1);
      a_up = 1'b0;
      cyc_n(1);
      a_up = 1'b1;
      pa(8'h00, 1'b1, 4);
      pa(8'h01, 1'b0, 4);
      cyc_n(8);
      #1;

      // Asynchronous reset mid-cycle
      pa(8'h00, 1'b0, 0);
      rst_n = 1'b0; a_en = 1'b0;
      #1;
      chk("midrst_a_count", a_count, 8'h00);
      chk("midrst_a_wrap", a_wrap, 1'b0);
      chk("midrst_a_ssd", a_ssd, 2'b10);
      chk("midrst_a_segs", a_segs, 8'h03);
      chk("midrst_b_ssd", b_ssd, 4'b1110);
      chk("midrst_b_segs", b_segs, 8'h03);
      cyc_n(3);
      chk("midrst_hold_ssd", b_ssd, 4'b1110);

      // Bring the 4-digit instance to 1234 and watch the scan
      rst_n = 1'b1; b_en = 1'b1;
      cyc_n(2468);
      b_en = 1'b0;
      cyc_n(2);
      chk("b_count_1234", b_count, 16'h1234);
      wait_sel(4'b1110, 8'h99, "scan_d0_4");
      pb(4'b1101, 8'h0D); pb(4'b1011, 8'h25); pb(4'b0111, 8'h9F); pb(4'b1110, 8'h99);
      pb(4'b1101, 8'h0D); pb(4'b1011, 8'h25); pb(4'b0111, 8'h9F); pb(4'b1110, 8'h99);
      #1;
      b_mon = 1'b1;
      cyc_n(25);
      b_mon = 1'b0;
      chk("b_queue_empty", qb.size(), 0);

      // Clear while disabled, then count to 0050 for the leading-zero display
      b_clr = 1'b1;
      cyc_n(1);
      chk("clr_while_disabled", b_count, 16'h0000);
      b_clr = 1'b0; b_en = 1'b1;
      cyc_n(100);
      b_en = 1'b0;
      cyc_n(2);
      chk("b_count_0050", b_count, 16'h0050);
`ifdef BCD_SSD_BLANK_LEADING_ZERO_EN
      wait_sel(4'b0111, 8'hFF, "lz_d3");
      wait_sel(4'b1011, 8'hFF, "lz_d2");
`else
      wait_sel(4'b0111, 8'h03, "lz_d3");
      wait_sel(4'b1011, 8'h03, "lz_d2");
`endif
      wait_sel(4'b1101, 8'h49, "lz_d1");
      wait_sel(4'b1110, 8'h03, "lz_d0");

      chk("a_queue_empty", qa.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
